// File: rtl/cr_huf_comp_st_fsm_nbuf.sv
// N_BUF-deep symbol-table handoff controller between the TW/ST LUT writers and the SA reader.
// Define CR_HUF_COMP_ST_FSM_ERR_EN to generate the st_err illegal-event pulse; otherwise st_err is tied low.

package cr_huf_comp_st_fsm_nbuf_pkg;
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      START_STCL    = 2'd1,
      RDY_TO_SA     = 2'd2,
      TBL_RDY_TO_SA = 2'd3
   } e_st_state;
endpackage

module cr_huf_comp_st_fsm_nbuf
   import cr_huf_comp_st_fsm_nbuf_pkg::*;
#(
   parameter  int N_BUF = 2,
   localparam int IDX_W = ($clog2(N_BUF) < 1) ? 1 : $clog2(N_BUF)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tw_pass_thru_rdy,
   input  logic             tw_code_rdy,
   input  logic             st_stcl_lut_wr_done,
   input  logic             st_st_lut_wr_done,
   input  logic             sa_st_read_done,
   output e_st_state        st_curr_st,
   output e_st_state        st_nxt_st,
   output e_st_state        st_bld_st,
   output logic [IDX_W-1:0] st_bld_idx,
   output logic [IDX_W-1:0] st_rd_idx,
   output logic             st_full,
   output logic             st_empty,
   output logic [IDX_W:0]   st_occ,
   output logic             st_err
);

   e_st_state        state_q [N_BUF];
   e_st_state        state_d [N_BUF];
   logic [IDX_W-1:0] bld_q, bld_d;
   logic [IDX_W-1:0] rd_q, rd_d;
   logic [IDX_W:0]   occ_q, occ_d;

   logic start_ev;
   logic start_ok;
   logic stcl_ok;
   logic lut_legal;
   logic lut_ok;
   logic rd_ok;
   logic pt_done;

   // Pointers wrap at N_BUF-1, which need not be a power of two.
   function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
      if (p == IDX_W'(N_BUF - 1))
         return '0;
      return p + IDX_W'(1);
   endfunction

   always_comb begin
      start_ev  = tw_pass_thru_rdy | tw_code_rdy;
      start_ok  = start_ev && (state_q[bld_q] == ST_IDLE);
      stcl_ok   = st_stcl_lut_wr_done && (state_q[bld_q] == START_STCL);
      lut_legal = st_st_lut_wr_done && (state_q[bld_q] == RDY_TO_SA);
      rd_ok     = sa_st_read_done &&
                  ((state_q[rd_q] == RDY_TO_SA) || (state_q[rd_q] == TBL_RDY_TO_SA));
      // A read-done on the build buffer swallows a same-cycle lut-done.
      lut_ok    = lut_legal && !(rd_ok && (rd_q == bld_q));
      // Pass-through table finished by SA before any lut-done: the builder moves on too.
      pt_done   = rd_ok && (rd_q == bld_q) && (state_q[rd_q] == RDY_TO_SA);
   end

   always_comb begin
      state_d = state_q;
      bld_d   = bld_q;
      rd_d    = rd_q;

      if (start_ok)
         state_d[bld_q] = tw_pass_thru_rdy ? RDY_TO_SA : START_STCL;
      if (stcl_ok)
         state_d[bld_q] = RDY_TO_SA;
      if (lut_ok) begin
         state_d[bld_q] = TBL_RDY_TO_SA;
         bld_d          = ptr_inc(bld_q);
      end
      if (rd_ok) begin
         state_d[rd_q] = ST_IDLE;
         rd_d          = ptr_inc(rd_q);
         if (pt_done)
            bld_d = ptr_inc(bld_q);
      end
   end

   always_comb begin
      occ_d = occ_q;
      unique case ({start_ok, rd_ok})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_BUF; i++)
            state_q[i] <= ST_IDLE;
         bld_q <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         state_q <= state_d;
         bld_q   <= bld_d;
         rd_q    <= rd_d;
         occ_q   <= occ_d;
      end
   end

`ifdef CR_HUF_COMP_ST_FSM_ERR_EN
   logic err_d;
   logic err_q;

   always_comb begin
      err_d = (start_ev && !start_ok)             ||
              (st_stcl_lut_wr_done && !stcl_ok)   ||
              (st_st_lut_wr_done && !lut_legal)   ||
              (sa_st_read_done && !rd_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign st_err = err_q;
`else
   assign st_err = 1'b0;
`endif

   always_comb begin
      st_empty = 1'b1;
      for (int i = 0; i < N_BUF; i++)
         if (state_q[i] != ST_IDLE)
            st_empty = 1'b0;
   end

   assign st_curr_st = state_q[rd_q];
   assign st_nxt_st  = state_d[rd_q];
   assign st_bld_st  = state_q[bld_q];
   assign st_bld_idx = bld_q;
   assign st_rd_idx  = rd_q;
   assign st_full    = (state_q[bld_q] != ST_IDLE);
   assign st_occ     = occ_q;

endmodule

// File: tb/tb_cr_huf_comp_st_fsm_nbuf.sv
// Scoreboard bench for cr_huf_comp_st_fsm_nbuf with N_BUF=3: directed event vectors, hand-computed expectations.
module tb_cr_huf_comp_st_fsm_nbuf;
   import cr_huf_comp_st_fsm_nbuf_pkg::*;

`ifdef CR_HUF_COMP_ST_FSM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam logic [4:0] NONE = 5'b00000;
   localparam logic [4:0] PT   = 5'b10000;
   localparam logic [4:0] CD   = 5'b01000;
   localparam logic [4:0] SD   = 5'b00100;
   localparam logic [4:0] LD   = 5'b00010;
   localparam logic [4:0] RD   = 5'b00001;

   localparam e_st_state I = ST_IDLE;
   localparam e_st_state S = START_STCL;
   localparam e_st_state R = RDY_TO_SA;
   localparam e_st_state T = TBL_RDY_TO_SA;

   logic      clk;
   logic      rst_n;
   logic      tw_pass_thru_rdy, tw_code_rdy, st_stcl_lut_wr_done, st_st_lut_wr_done, sa_st_read_done;
   e_st_state st_curr_st, st_nxt_st, st_bld_st;
   logic [1:0] st_bld_idx, st_rd_idx;
   logic      st_full, st_empty, st_err;
   logic [2:0] st_occ;

   cr_huf_comp_st_fsm_nbuf #(.N_BUF(3)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .tw_pass_thru_rdy    (tw_pass_thru_rdy),
      .tw_code_rdy         (tw_code_rdy),
      .st_stcl_lut_wr_done (st_stcl_lut_wr_done),
      .st_st_lut_wr_done   (st_st_lut_wr_done),
      .sa_st_read_done     (sa_st_read_done),
      .st_curr_st          (st_curr_st),
      .st_nxt_st           (st_nxt_st),
      .st_bld_st           (st_bld_st),
      .st_bld_idx          (st_bld_idx),
      .st_rd_idx           (st_rd_idx),
      .st_full             (st_full),
      .st_empty            (st_empty),
      .st_occ              (st_occ),
      .st_err              (st_err)
   );

   typedef struct {
      int        due;
      bit        is_nxt;
      string     name;
      e_st_state nxt;
      e_st_state cur;
      e_st_state bst;
      int        bi;
      int        ri;
      int        occ;
      bit        full;
      bit        empty;
      bit        err;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every expectation that has come due, away from the active edge.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (e.is_nxt) begin
            if (st_nxt_st !== e.nxt) begin
               errors++;
               $display("FAIL %s.nxt: got st_nxt_st=%0d, want %0d", e.name, st_nxt_st, e.nxt);
            end
         end else if (st_curr_st !== e.cur || st_bld_st !== e.bst ||
                      st_bld_idx !== 2'(e.bi) || st_rd_idx !== 2'(e.ri) ||
                      st_occ !== 3'(e.occ) || st_full !== e.full ||
                      st_empty !== e.empty || st_err !== e.err) begin
            errors++;
            $display("FAIL %s: got cur=%0d bst=%0d bi=%0d ri=%0d occ=%0d full=%0b empty=%0b err=%0b, want cur=%0d bst=%0d bi=%0d ri=%0d occ=%0d full=%0b empty=%0b err=%0b",
                     e.name, st_curr_st, st_bld_st, st_bld_idx, st_rd_idx, st_occ, st_full, st_empty, st_err,
                     e.cur, e.bst, e.bi, e.ri, e.occ, e.full, e.empty, e.err);
         end
      end
   end

   task automatic push_reg(input string nm, input int due, input e_st_state cu, bs,
                           input int bi, ri, oc, input bit fu, em, er);
      exp_t e;
      e.due = due; e.is_nxt = 1'b0; e.name = nm; e.nxt = I;
      e.cur = cu; e.bst = bs; e.bi = bi; e.ri = ri; e.occ = oc;
      e.full = fu; e.empty = em; e.err = er & ERR_EN;
      sb.push_back(e);
   endtask

   // One event cycle: nxt is checked in the drive cycle, registered outputs one edge later.
   task automatic step(input string nm, input logic [4:0] ev, input e_st_state nx, cu, bs,
                       input int bi, ri, oc, input bit fu, em, er);
      exp_t e;
      @(posedge clk);
      #1;
      {tw_pass_thru_rdy, tw_code_rdy, st_stcl_lut_wr_done, st_st_lut_wr_done, sa_st_read_done} = ev;
      e.due = cyc; e.is_nxt = 1'b1; e.name = nm; e.nxt = nx;
      e.cur = I; e.bst = I; e.bi = 0; e.ri = 0; e.occ = 0; e.full = 0; e.empty = 0; e.err = 0;
      sb.push_back(e);
      push_reg(nm, cyc + 1, cu, bs, bi, ri, oc, fu, em, er);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached with %0d expectations pending", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      {tw_pass_thru_rdy, tw_code_rdy, st_stcl_lut_wr_done, st_st_lut_wr_done, sa_st_read_done} = NONE;
      repeat (2) @(posedge clk);
      #1;
      push_reg("reset_held", cyc, I, I, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_reg("reset_release", cyc, I, I, 0, 0, 0, 0, 1, 0);

      //      name            ev       nxt cur bst bi ri occ full empty err
      step("code_start",      CD,      S,  S,  S,  0, 0, 1,  1,   0,    0);
      step("stcl_done",       SD,      R,  R,  R,  0, 0, 1,  1,   0,    0);
      step("lut_done",        LD,      T,  T,  I,  1, 0, 1,  0,   0,    0);
      step("read_coded",      RD,      I,  I,  I,  1, 1, 0,  0,   1,    0);
      step("pt_start",        PT,      R,  R,  R,  1, 1, 1,  1,   0,    0);
      step("pt_read",         RD,      I,  I,  I,  2, 2, 0,  0,   1,    0);
      step("read_empty",      RD,      I,  I,  I,  2, 2, 0,  0,   1,    1);
      step("stcl_idle",       SD,      I,  I,  I,  2, 2, 0,  0,   1,    1);
      step("err_clears",      NONE,    I,  I,  I,  2, 2, 0,  0,   1,    0);
      step("fill_start1",     CD,      S,  S,  S,  2, 2, 1,  1,   0,    0);
      step("fill_stcl1",      SD,      R,  R,  R,  2, 2, 1,  1,   0,    0);
      step("fill_lut1_wrap",  LD,      T,  T,  I,  0, 2, 1,  0,   0,    0);
      step("fill_both_start", PT | CD, T,  T,  R,  0, 2, 2,  1,   0,    0);
      step("fill_lut2",       LD,      T,  T,  I,  1, 2, 2,  0,   0,    0);
      step("fill_start3",     CD,      T,  T,  S,  1, 2, 3,  1,   0,    0);
      step("start_when_full", CD,      T,  T,  S,  1, 2, 3,  1,   0,    1);
      step("rd_wrap_and_stcl",RD | SD, I,  T,  R,  1, 0, 2,  1,   0,    0);
      step("drain_buf0",      RD,      I,  R,  R,  1, 1, 1,  1,   0,    0);
      step("rd_lut_conflict", RD | LD, I,  I,  I,  2, 2, 0,  0,   1,    0);
      step("pt_start_b2",     PT,      R,  R,  R,  2, 2, 1,  1,   0,    0);
      step("lut_b2",          LD,      T,  T,  I,  0, 2, 1,  0,   0,    0);
      step("start_and_read",  CD | RD, I,  S,  S,  0, 0, 1,  1,   0,    0);
      step("lut_in_stcl",     LD,      S,  S,  S,  0, 0, 1,  1,   0,    1);
      step("read_in_stcl",    RD,      S,  S,  S,  0, 0, 1,  1,   0,    1);
      step("stcl_b0",         SD,      R,  R,  R,  0, 0, 1,  1,   0,    0);
      step("pt_when_full",    PT,      R,  R,  R,  0, 0, 1,  1,   0,    1);
      step("lut_b0",          LD,      T,  T,  I,  1, 0, 1,  0,   0,    0);
      step("pt_b1_occ2",      PT,      T,  T,  R,  1, 0, 2,  1,   0,    0);
      step("idle_before_rst", NONE,    T,  T,  R,  1, 0, 2,  1,   0,    0);

      // Drop reset mid-cycle; the check lands on the following negedge, before any clock edge.
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      push_reg("async_reset", cyc, I, I, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      push_reg("reset_hold", cyc, I, I, 0, 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_reg("reset_release2", cyc, I, I, 0, 0, 0, 0, 1, 0);

      step("post_rst_start",  CD,      S,  S,  S,  0, 0, 1,  1,   0,    0);
      step("final_idle",      NONE,    S,  S,  S,  0, 0, 1,  1,   0,    0);

      for (int i = 0; i < 20 && sb.size() > 0; i++)
         @(posedge clk);
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations never came due, want 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
